count_err_mc: RTL and testbench

- Parametrised, multi-channel successor to the single 4-bit count/prevcount error checker.
- Monitors NUM_CH independent counters of WIDTH bits and flags any illegal step between consecutive valid samples.
- Per-channel step rule is selected at run time by a mode input.
- Reports one-cycle error pulses, sticky flags, a saturating error total, and a capture of the first error.
- Sits beside any counter-bearing datapath as a synthesizable monitor.

---
 rtl/count_err_pkg.sv | 9 +
 rtl/count_err_chan.sv | 44 ++++
 rtl/count_err_mc.sv | 86 ++++++++
 tb/tb_count_err_mc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_err_pkg.sv
// count_err_pkg: shared mode/state types and popcount helper for the counter error monitor.
package count_err_pkg;
  typedef enum logic [1:0] {UP, DOWN, UPDOWN, OFF} mode_e;
  typedef enum logic {UNARMED, ARMED} chst_e;
  function automatic logic [5:0] popcount(input logic [31:0] v);
    popcount = '0;
    for (int i = 0; i < 32; i++) popcount += 6'(v[i]);
  endfunction
endpackage

// File: rtl/count_err_chan.sv
// count_err_chan: one channel's arm FSM, prevcount register and step check.
// COUNT_ERR_HOLD_EN makes an unchanged count a legal step.
module count_err_chan
  import count_err_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             valid,
  input  mode_e            mode,
  output logic             err,
  output logic [WIDTH-1:0] expected
);
  chst_e st, st_nx;
  logic [WIDTH-1:0] prev;
  logic load, up, dn, hold, legal;
  assign up = count == prev + WIDTH'(1);
  assign dn = count == prev - WIDTH'(1);
`ifdef COUNT_ERR_HOLD_EN
  assign hold = count == prev;
`else
  assign hold = 1'b0;
`endif
  assign legal = hold | (mode == UP ? up : mode == DOWN ? dn : up | dn);
  assign expected = mode == DOWN ? prev - WIDTH'(1) : prev + WIDTH'(1);
  always_ff @(posedge clk) begin
    st <= reset ? UNARMED : st_nx;
    if (reset) prev <= '0;
    else if (load) prev <= count;
  end
  always_comb begin
    st_nx = st;
    load = 1'b0;
    err = 1'b0;
    if (mode == OFF) st_nx = UNARMED;
    else if (valid) begin
      st_nx = ARMED;
      load = 1'b1;
      err = st == ARMED && !legal;
    end
  end
endmodule

// File: rtl/count_err_mc.sv
// count_err_mc: multi-channel counter step monitor with pulses, sticky flags, total and first-error capture.
// Optional COUNT_ERR_HOLD_EN (in count_err_chan) accepts stalled counters.
module count_err_mc
  import count_err_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NUM_CH = 4,
  parameter int ERRCNT_W = 8,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] count,
  input  logic [NUM_CH-1:0]       valid,
  input  logic [NUM_CH*2-1:0]     mode,
  input  logic                    clr,
  output logic [NUM_CH-1:0]       err_pulse,
  output logic [NUM_CH-1:0]       err_sticky,
  output logic [ERRCNT_W-1:0]     err_total,
  output logic                    first_vld,
  output logic [CH_W-1:0]         first_ch,
  output logic [WIDTH-1:0]        first_exp,
  output logic [WIDTH-1:0]        first_act
);
  logic [NUM_CH-1:0] err;
  logic [NUM_CH*WIDTH-1:0] expv;
  logic [CH_W-1:0] win_ch;
  logic [WIDTH-1:0] win_exp, win_act;
  logic [ERRCNT_W+5:0] sum;
  logic [ERRCNT_W-1:0] tot_nx;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    count_err_chan #(.WIDTH(WIDTH)) u_ch (
      .clk(clk),
      .reset(reset),
      .count(count[i*WIDTH +: WIDTH]),
      .valid(valid[i]),
      .mode(mode_e'(mode[2*i +: 2])),
      .err(err[i]),
      .expected(expv[i*WIDTH +: WIDTH])
    );
  end
  // descending scan so the lowest failing channel is the last one written
  always_comb begin
    win_ch = '0;
    win_exp = '0;
    win_act = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (err[k]) begin
        win_ch = CH_W'(k);
        win_exp = expv[k*WIDTH +: WIDTH];
        win_act = count[k*WIDTH +: WIDTH];
      end
  end
  assign sum = {6'd0, err_total} + {{ERRCNT_W{1'b0}}, popcount(32'(err))};
  assign tot_nx = |sum[ERRCNT_W+5:ERRCNT_W] ? '1 : sum[ERRCNT_W-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= '0;
      err_sticky <= '0;
      err_total <= '0;
      first_vld <= 1'b0;
      first_ch <= '0;
      first_exp <= '0;
      first_act <= '0;
    end else begin
      err_pulse <= err;
      if (clr) begin
        err_sticky <= '0;
        err_total <= '0;
        first_vld <= 1'b0;
        first_ch <= '0;
        first_exp <= '0;
        first_act <= '0;
      end else begin
        err_sticky <= err_sticky | err;
        err_total <= tot_nx;
        if (!first_vld && |err) begin
          first_vld <= 1'b1;
          first_ch <= win_ch;
          first_exp <= win_exp;
          first_act <= win_act;
        end
      end
    end
  end
endmodule

// File: tb/tb_count_err_mc.sv
// tb_count_err_mc: directed vector table, hand sequences and randomized run against a reference model.
module tb_count_err_mc;
  logic clk = 1'b0;
  logic reset, clr;
  logic [3:0] valid;
  logic [7:0] mode;
  logic [15:0] count;
  logic [3:0] err_pulse, err_sticky, first_exp, first_act;
  logic [7:0] err_total;
  logic first_vld;
  logic [1:0] first_ch;
  logic [3:0] s_pulse, s_sticky, s_exp, s_act;
  logic [1:0] s_total, s_ch;
  logic s_vld;

  localparam bit hold_en =
`ifdef COUNT_ERR_HOLD_EN
    1'b1;
`else
    1'b0;
`endif

  count_err_mc dut (
    .clk(clk), .reset(reset), .count(count), .valid(valid), .mode(mode), .clr(clr),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_total(err_total),
    .first_vld(first_vld), .first_ch(first_ch), .first_exp(first_exp), .first_act(first_act)
  );
  count_err_mc #(.ERRCNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .count(count), .valid(valid), .mode(mode), .clr(clr),
    .err_pulse(s_pulse), .err_sticky(s_sticky), .err_total(s_total),
    .first_vld(s_vld), .first_ch(s_ch), .first_exp(s_exp), .first_act(s_act)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: spec rules with plain modular arithmetic
  bit m_armed[4];
  int m_prev[4];
  logic [3:0] m_pulse, m_sticky;
  int m_total, m_total_s, m_fch, m_fexp, m_fact;
  bit m_fv;

  task automatic model_step();
    int md, c, d, first, fe, fa;
    bit ok;
    m_pulse = '0;
    if (reset) begin
      for (int ch = 0; ch < 4; ch++) m_armed[ch] = 0;
      m_sticky = '0; m_total = 0; m_total_s = 0; m_fv = 0; m_fch = 0; m_fexp = 0; m_fact = 0;
      return;
    end
    first = -1; fe = 0; fa = 0;
    for (int ch = 0; ch < 4; ch++) begin
      md = int'(mode[2*ch +: 2]);
      c = int'(count[4*ch +: 4]);
      if (md == 3) m_armed[ch] = 0;
      else if (valid[ch]) begin
        if (m_armed[ch]) begin
          d = (c - m_prev[ch] + 16) % 16;
          ok = (md == 0 && d == 1) || (md == 1 && d == 15) || (md == 2 && (d == 1 || d == 15)) ||
               (hold_en && d == 0);
          if (!ok) begin
            m_pulse[ch] = 1'b1;
            if (first < 0) begin
              first = ch;
              fe = md == 1 ? (m_prev[ch] + 15) % 16 : (m_prev[ch] + 1) % 16;
              fa = c;
            end
          end
        end
        m_prev[ch] = c;
        m_armed[ch] = 1;
      end
    end
    if (clr) begin
      m_sticky = '0; m_total = 0; m_total_s = 0; m_fv = 0; m_fch = 0; m_fexp = 0; m_fact = 0;
    end else begin
      m_sticky |= m_pulse;
      m_total = m_total + $countones(m_pulse) > 255 ? 255 : m_total + $countones(m_pulse);
      m_total_s = m_total_s + $countones(m_pulse) > 3 ? 3 : m_total_s + $countones(m_pulse);
      if (!m_fv && first >= 0) begin
        m_fv = 1; m_fch = first; m_fexp = fe; m_fact = fa;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic compare_model(input int n);
    chk($sformatf("rnd%0d pulse", n), 32'(err_pulse), 32'(m_pulse));
    chk($sformatf("rnd%0d sticky", n), 32'(err_sticky), 32'(m_sticky));
    chk($sformatf("rnd%0d total", n), 32'(err_total), 32'(m_total));
    chk($sformatf("rnd%0d total_sat2", n), 32'(s_total), 32'(m_total_s));
    chk($sformatf("rnd%0d first_vld", n), 32'(first_vld), 32'(m_fv));
    chk($sformatf("rnd%0d first_ch", n), 32'(first_ch), 32'(m_fch));
    chk($sformatf("rnd%0d first_exp", n), 32'(first_exp), 32'(m_fexp));
    chk($sformatf("rnd%0d first_act", n), 32'(first_act), 32'(m_fact));
  endtask

  typedef struct {
    logic rst, clr;
    logic [3:0] v;
    logic [7:0] m;
    logic [15:0] c;
    logic [3:0] pulse, sticky;
    logic [7:0] total;
    logic fv;
    logic [1:0] fch;
    logic [3:0] fexp, fact;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic rst, input logic cl, input logic [3:0] v, input logic [7:0] m,
                     input logic [15:0] c, input logic [3:0] pulse, input logic [3:0] sticky,
                     input logic [7:0] total, input logic fv, input logic [1:0] fch,
                     input logic [3:0] fexp, input logic [3:0] fact);
    vec_t e;
    e.rst = rst; e.clr = cl; e.v = v; e.m = m; e.c = c; e.pulse = pulse; e.sticky = sticky;
    e.total = total; e.fv = fv; e.fch = fch; e.fexp = fexp; e.fact = fact;
    vq.push_back(e);
  endtask

  task automatic drive(input logic r, input logic cl, input logic [3:0] v, input logic [7:0] m,
                       input logic [15:0] c);
    reset = r; clr = cl; valid = v; mode = m; count = c;
  endtask

  int gen[4];

  initial begin
    drive(1, 0, 0, 0, 0);
    // directed table (mode 8'h90: ch3 UPDOWN, ch2 DOWN, ch1/ch0 UP)
    add(1, 0, 4'h0, 8'h00, 16'h0000, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    for (int k = 0; k <= 16; k++)
      add(0, 0, 4'h1, 8'h00, 16'(k % 16), 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h2, 8'h00, 16'h0030, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h2, 8'h00, 16'h0040, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h2, 8'h00, 16'h0060, 4'h2, 4'h2, 8'd1, 1, 1, 4'h5, 4'h6);
    add(0, 0, 4'h2, 8'h00, 16'h0070, 4'h0, 4'h2, 8'd1, 1, 1, 4'h5, 4'h6);
    add(0, 0, 4'hC, 8'h90, 16'h5100, 4'h0, 4'h2, 8'd1, 1, 1, 4'h5, 4'h6);
    add(0, 0, 4'hC, 8'h90, 16'h6000, 4'h0, 4'h2, 8'd1, 1, 1, 4'h5, 4'h6);
    add(0, 0, 4'hC, 8'h90, 16'h5F00, 4'h0, 4'h2, 8'd1, 1, 1, 4'h5, 4'h6);
    add(0, 0, 4'hC, 8'h90, 16'h4E00, 4'h0, 4'h2, 8'd1, 1, 1, 4'h5, 4'h6);
    add(0, 0, 4'h8, 8'h90, 16'h5000, 4'h0, 4'h2, 8'd1, 1, 1, 4'h5, 4'h6);
    add(0, 0, 4'h8, 8'h90, 16'h7000, 4'h8, 4'hA, 8'd2, 1, 1, 4'h5, 4'h6);
    add(0, 1, 4'h0, 8'h90, 16'h0000, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h5, 8'h90, 16'h0305, 4'h5, 4'h5, 8'd2, 1, 0, 4'h1, 4'h5);
    add(0, 1, 4'h2, 8'h90, 16'h0020, 4'h2, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h0, 8'h90, 16'h0000, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h2, 8'h9C, 16'h0020, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h2, 8'h9C, 16'h0090, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h2, 8'h90, 16'h0040, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h2, 8'h90, 16'h0050, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(1, 0, 4'h0, 8'h90, 16'h0000, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h1, 8'h90, 16'h0009, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h1, 8'h90, 16'h000A, 4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 4'h1, 8'h90, 16'h000C, 4'h1, 4'h1, 8'd1, 1, 0, 4'hB, 4'hC);
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].clr, vq[i].v, vq[i].m, vq[i].c);
      cycle();
      chk($sformatf("row%0d pulse", i), 32'(err_pulse), 32'(vq[i].pulse));
      chk($sformatf("row%0d sticky", i), 32'(err_sticky), 32'(vq[i].sticky));
      chk($sformatf("row%0d total", i), 32'(err_total), 32'(vq[i].total));
      chk($sformatf("row%0d first_vld", i), 32'(first_vld), 32'(vq[i].fv));
      chk($sformatf("row%0d first_ch", i), 32'(first_ch), 32'(vq[i].fch));
      chk($sformatf("row%0d first_exp", i), 32'(first_exp), 32'(vq[i].fexp));
      chk($sformatf("row%0d first_act", i), 32'(first_act), 32'(vq[i].fact));
    end
    // saturation: five bad UP steps on ch0
    drive(1, 0, 0, 0, 0);
    cycle();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 4'h1, 8'h00, (k % 2) ? 16'h0005 : 16'h0000);
      cycle();
    end
    chk("sat last pulse", 32'(err_pulse), 32'h1);
    chk("sat total8", 32'(err_total), 32'd5);
    chk("sat total2", 32'(s_total), 32'd3);
    // reset mid-stream: first sample only arms
    drive(1, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 4'h1, 8'h00, 16'h0009);
    cycle();
    chk("post-reset arm pulse", 32'(err_pulse), 32'h0);
    chk("post-reset total", 32'(err_total), 32'd0);
    // hold 9 -> 9
    cycle();
    chk("hold pulse", 32'(err_pulse), hold_en ? 32'h0 : 32'h1);
    // OFF on 2, 9 then UP re-arm on 4
    drive(0, 0, 4'h1, 8'h03, 16'h0002);
    cycle();
    chk("off 2 pulse", 32'(err_pulse), 32'h0);
    drive(0, 0, 4'h1, 8'h03, 16'h0009);
    cycle();
    chk("off 9 pulse", 32'(err_pulse), 32'h0);
    drive(0, 0, 4'h1, 8'h00, 16'h0004);
    cycle();
    chk("rearm pulse", 32'(err_pulse), 32'h0);
    // randomized run against the model
    drive(1, 0, 0, 0, 0);
    cycle();
    for (int ch = 0; ch < 4; ch++) gen[ch] = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] m;
      logic [15:0] c;
      int r;
      for (int ch = 0; ch < 4; ch++) begin
        m[2*ch +: 2] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        r = $urandom_range(0, 9);
        gen[ch] = r < 4 ? (gen[ch] + 1) % 16 : r < 7 ? (gen[ch] + 15) % 16 :
                  r < 8 ? gen[ch] : $urandom_range(0, 15);
        c[4*ch +: 4] = 4'(gen[ch]);
      end
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0, 4'($urandom), m, c);
      cycle();
      compare_model(n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
